// File: rtl/ctrl_pkg.sv
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared opcodes, control-word bit map and T-state encoding
//               for the 8-bit computer control sequencer.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

   localparam int CW_WIDTH = 16;
   localparam int T_STATES = 5;

   typedef logic [3:0]          opcode_t;
   typedef logic [CW_WIDTH-1:0] ctrl_word_t;

   localparam opcode_t OP_NOP = 4'h0;
   localparam opcode_t OP_LDA = 4'h1;
   localparam opcode_t OP_ADD = 4'h2;
   localparam opcode_t OP_SUB = 4'h3;
   localparam opcode_t OP_STA = 4'h4;
   localparam opcode_t OP_LDI = 4'h5;
   localparam opcode_t OP_JMP = 4'h6;
   localparam opcode_t OP_JC  = 4'h7;
   localparam opcode_t OP_JZ  = 4'h8;
   localparam opcode_t OP_OUT = 4'hE;
   localparam opcode_t OP_HLT = 4'hF;

   localparam int CW_HLT = 15;
   localparam int CW_MI  = 14;
   localparam int CW_RI  = 13;
   localparam int CW_RO  = 12;
   localparam int CW_IO  = 11;
   localparam int CW_II  = 10;
   localparam int CW_AI  = 9;
   localparam int CW_AO  = 8;
   localparam int CW_EO  = 7;
   localparam int CW_SU  = 6;
   localparam int CW_BI  = 5;
   localparam int CW_OI  = 4;
   localparam int CW_CE  = 3;
   localparam int CW_CO  = 2;
   localparam int CW_J   = 1;
   localparam int CW_FI  = 0;

   typedef enum logic [2:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } tstate_e;

endpackage

`default_nettype wire

// File: rtl/control_unit_if.sv
// ============================================================================
// Module      : control_unit_if
// Description : Control-strobe and status bundle between the sequencer
//               (master) and the datapath (slave).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface control_unit_if;

   ctrl_pkg::opcode_t opcode;
   logic              alu_carry;
   logic              alu_zero;
   logic              hlt;
   logic              mi, ri, ro;
   logic              io, ii;
   logic              ai, ao, bi;
   logic              eo, su, fi;
   logic              oi;
   logic              ce, co, j;
   logic [2:0]        step;
   logic              flag_c, flag_z;

   modport master (
      input  opcode, alu_carry, alu_zero,
      output hlt, mi, ri, ro, io, ii, ai, ao, bi, eo, su, fi, oi, ce, co, j,
      output step, flag_c, flag_z
   );

   modport slave (
      output opcode, alu_carry, alu_zero,
      input  hlt, mi, ri, ro, io, ii, ai, ao, bi, eo, su, fi, oi, ce, co, j,
      input  step, flag_c, flag_z
   );

endinterface

`default_nettype wire

// File: rtl/ctrl_rom.sv
// ============================================================================
// Module      : ctrl_rom
// Description : Combinational microcode: (T-state, opcode, flags) -> control
//               word. Conditional jumps and fi depend on CONDITIONAL_JUMP_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_rom
   import ctrl_pkg::*;
(
   input  tstate_e    step_i,
   input  opcode_t    opcode_i,
   input  logic       flag_c_i,
   input  logic       flag_z_i,
   output ctrl_word_t ctrl_o
);

`ifndef CONDITIONAL_JUMP_EN
   logic w_unused_flags;
   assign w_unused_flags = flag_c_i ^ flag_z_i;
`endif

   always_comb begin
      ctrl_o = '0;
      case (step_i)
         T0: begin
            ctrl_o[CW_CO] = 1'b1;
            ctrl_o[CW_MI] = 1'b1;
         end
         T1: begin
            ctrl_o[CW_RO] = 1'b1;
            ctrl_o[CW_II] = 1'b1;
            ctrl_o[CW_CE] = 1'b1;
         end
         T2: begin
            case (opcode_i)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  ctrl_o[CW_IO] = 1'b1;
                  ctrl_o[CW_MI] = 1'b1;
               end
               OP_LDI: begin
                  ctrl_o[CW_IO] = 1'b1;
                  ctrl_o[CW_AI] = 1'b1;
               end
               OP_JMP: begin
                  ctrl_o[CW_IO] = 1'b1;
                  ctrl_o[CW_J]  = 1'b1;
               end
`ifdef CONDITIONAL_JUMP_EN
               // operand is always driven; only the PC load is conditional
               OP_JC: begin
                  ctrl_o[CW_IO] = 1'b1;
                  ctrl_o[CW_J]  = flag_c_i;
               end
               OP_JZ: begin
                  ctrl_o[CW_IO] = 1'b1;
                  ctrl_o[CW_J]  = flag_z_i;
               end
`endif
               OP_OUT: begin
                  ctrl_o[CW_AO] = 1'b1;
                  ctrl_o[CW_OI] = 1'b1;
               end
               OP_HLT: ctrl_o[CW_HLT] = 1'b1;
               default: ;
            endcase
         end
         T3: begin
            case (opcode_i)
               OP_LDA: begin
                  ctrl_o[CW_RO] = 1'b1;
                  ctrl_o[CW_AI] = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctrl_o[CW_RO] = 1'b1;
                  ctrl_o[CW_BI] = 1'b1;
               end
               OP_STA: begin
                  ctrl_o[CW_AO] = 1'b1;
                  ctrl_o[CW_RI] = 1'b1;
               end
               default: ;
            endcase
         end
         T4: begin
            if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
               ctrl_o[CW_EO] = 1'b1;
               ctrl_o[CW_AI] = 1'b1;
               ctrl_o[CW_SU] = (opcode_i == OP_SUB);
`ifdef CONDITIONAL_JUMP_EN
               ctrl_o[CW_FI] = 1'b1;
`endif
            end
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// Module      : control_unit
// Description : 5-state T-cycle sequencer with halt latch and flags register.
//               Optional feature macro: CONDITIONAL_JUMP_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_unit
   import ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   control_unit_if.master       bus
);

   tstate_e    step_q, step_d;
   logic       halted_q, halted_d;
   logic       flag_c_q, flag_z_q;
   ctrl_word_t rom_cw;
   ctrl_word_t cw;

   ctrl_rom u_rom (
      .step_i   (step_q),
      .opcode_i (bus.opcode),
      .flag_c_i (flag_c_q),
      .flag_z_i (flag_z_q),
      .ctrl_o   (rom_cw)
   );

   // reset wins over everything; a halted machine shows only hlt
   always_comb begin
      cw = rom_cw;
      if (rst) begin
         cw = '0;
      end else if (halted_q) begin
         cw         = '0;
         cw[CW_HLT] = 1'b1;
      end
   end

   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      if (!halted_q && rom_cw[CW_HLT]) begin
         halted_d = 1'b1;
      end
      if (!halted_d) begin
         case (step_q)
            T0:      step_d = T1;
            T1:      step_d = T2;
            T2:      step_d = T3;
            T3:      step_d = T4;
            T4:      step_d = T0;
            default: step_d = T0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
      end
   end

`ifdef CONDITIONAL_JUMP_EN
   logic flag_c_d, flag_z_d;

   always_comb begin
      flag_c_d = flag_c_q;
      flag_z_d = flag_z_q;
      if (cw[CW_FI]) begin
         flag_c_d = bus.alu_carry;
         flag_z_d = bus.alu_zero;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_c_q <= 1'b0;
         flag_z_q <= 1'b0;
      end else begin
         flag_c_q <= flag_c_d;
         flag_z_q <= flag_z_d;
      end
   end
`else
   logic w_unused_alu;
   assign w_unused_alu = bus.alu_carry ^ bus.alu_zero;
   assign flag_c_q     = 1'b0;
   assign flag_z_q     = 1'b0;
`endif

   assign bus.hlt    = cw[CW_HLT];
   assign bus.mi     = cw[CW_MI];
   assign bus.ri     = cw[CW_RI];
   assign bus.ro     = cw[CW_RO];
   assign bus.io     = cw[CW_IO];
   assign bus.ii     = cw[CW_II];
   assign bus.ai     = cw[CW_AI];
   assign bus.ao     = cw[CW_AO];
   assign bus.bi     = cw[CW_BI];
   assign bus.eo     = cw[CW_EO];
   assign bus.su     = cw[CW_SU];
   assign bus.fi     = cw[CW_FI];
   assign bus.oi     = cw[CW_OI];
   assign bus.ce     = cw[CW_CE];
   assign bus.co     = cw[CW_CO];
   assign bus.j      = cw[CW_J];
   assign bus.step   = step_q;
   assign bus.flag_c = flag_c_q;
   assign bus.flag_z = flag_z_q;

endmodule

`default_nettype wire

// File: doc/control_unit.md
# control_unit

Microcoded control sequencer for the 8-bit computer. It issues every bus-transfer control strobe, including CO/J/CE to the program counter, MI/RO/RI to memory, and the register and ALU enables. It steps through a fixed 5-state T-cycle per instruction, keeps the carry/zero flags register, and latches a halt state. It consumes the 4-bit opcode from the instruction register and the ALU flag outputs.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- opcode  input  4  instruction register upper nibble
- alu_carry  input  1  ALU carry-out, sampled when fi is high
- alu_zero  input  1  ALU result-is-zero, sampled when fi is high
- hlt  output  1  clock-halt request; level, held until reset
- mi, ri, ro  output  1 each  MAR in, RAM in, RAM out
- io, ii  output  1 each  IR operand out (low nibble), IR in
- ai, ao, bi  output  1 each  A in, A out, B in
- eo, su, fi  output  1 each  ALU out, subtract, flags in
- oi  output  1  output register in
- ce, co, j  output  1 each  PC count enable, PC out, PC jump (load)
- step  output  3  current T-state 0..4 (debug)
- flag_c, flag_z  output  1 each  stored flags

## Operation
- Control word is a combinational function of (step, opcode, flag_c, flag_z, halted).
- Microcode (T0/T1 common fetch):
  - T0: co mi
  - T1: ro ii ce
- Per-opcode T2/T3/T4 (steps not listed are empty):
  - 0000 NOP: none
  - 0001 LDA: io mi / ro ai
  - 0010 ADD: io mi / ro bi / eo ai fi
  - 0011 SUB: io mi / ro bi / eo ai su fi
  - 0100 STA: io mi / ao ri
  - 0101 LDI: io ai
  - 0110 JMP: io j
  - 0111 JC: io j only if flag_c
  - 1000 JZ: io j only if flag_z
  - 1110 OUT: ao oi
  - 1111 HLT: hlt
  - 1001–1101: NOP
- Step counter:
  - 0→1→2→3→4→0 every clock.
  - No early termination; every instruction takes exactly 5 cycles.
- Flags: on a rising edge with fi high, flag_c ← alu_carry and flag_z ← alu_zero. Otherwise they hold.
- Halt:
  - A rising edge at which the HLT microinstruction is active sets halted.
  - While halted: step freezes, hlt=1, and all other control outputs are 0.
  - Only rst clears halted.

## Timing
- Reset:
  - While rst is high, all control outputs are forced 0, including hlt.
  - At the next edge: step=0, halted=0, flag_c=0, flag_z=0.
  - First cycle after rst deasserts: co=mi=1 (T0).
- Control outputs change only after a rising edge. They are stable for the whole cycle and are sampled by bus targets at the following edge.
- Fetch-to-execute latency: opcode must be valid from T2. It is loaded by ii at the T1→T2 edge.
- fi and a conditional jump in the same instruction are impossible. Flags written by ADD/SUB at T4 are visible to the next instruction's T2.
- rst mid-instruction (any step, halted or not) takes priority over halt, step advance and flag load.

## Configuration
- CONDITIONAL_JUMP_EN defined:
  - JC/JZ are decoded as above.
  - The flags register and fi update are present.
- Undefined:
  - 0111 and 1000 decode as NOP.
  - fi is never asserted by ADD/SUB.
  - flag_c and flag_z are tied 0.
  - alu_carry and alu_zero are ignored.

## Structure
- Shared package `ctrl_pkg`:
  - opcode constants (OP_NOP … OP_HLT)
  - control-word bit indices and width (16)
  - T-state count (5)
- Sub-module `ctrl_rom`: purely combinational. Maps (step, opcode, flag_c, flag_z) to the 16-bit control word.
- Top level `control_unit` holds:
  - step counter
  - halted latch
  - flags register
  - rst/halt output gating

## Test plan
- Reset, release, free-run NOP (0000): steps cycle 0,1,2,3,4,0; T0 co+mi only; T1 ro+ii+ce only; T2–T4 all zero.
- ADD with alu_carry=1, alu_zero=0: T2 io+mi, T3 ro+bi, T4 eo+ai+fi. After the T4 edge, flag_c=1 and flag_z=0. SUB additionally asserts su at T4.
- JC with flag_c=1 → j+io at T2. Same with flag_c=0 → io only, j=0. Repeat for JZ. With CONDITIONAL_JUMP_EN undefined, both are NOP.
- HLT (1111) at T2: hlt=1 from the following cycle. Step stays 2 for 10 cycles and all other outputs stay 0. rst then restores step=0 and T0 co+mi.
- rst asserted at T3 of LDA: outputs are 0 in that cycle. Next cycle step=0 and flags are 0.
- OUT and STA: T2 ao+oi for OUT. STA gives T2 io+mi, then T3 ao+ri, with no other strobes.
